apb_reg_bank: RTL and testbench

Parametrised APB3/APB4 slave that replaces the single-register command/status interface with a bank of `NUM_CMD` writable command registers and `NUM_STAT` read-only status inputs. It adds configurable wait states, byte strobes, address decode with error response, and per-register write strobes. It sits between the APB interconnect and the core control logic. Command registers drive the core; status words are sampled from the core.

---
 rtl/apb_reg_bank.sv | 135 +++++++++++++
 tb/tb_apb_reg_bank.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_reg_bank.sv
// APB3/APB4 slave exposing NUM_CMD read/write command registers and NUM_STAT
// read-only status words, with byte strobes, wait states and error response.
module apb_reg_bank #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 8,
  parameter int                NUM_CMD     = 4,
  parameter int                NUM_STAT    = 4,
  parameter int                STAT_BASE   = 'h40,
  parameter int                WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] CMD_RESET   = '0
) (
  input  logic                       pclk,
  input  logic                       rst,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [ADDR_W-1:0]          paddr,
  input  logic [DATA_W-1:0]          pwdata,
  input  logic [DATA_W/8-1:0]        pstrb,
  output logic [DATA_W-1:0]          prdata,
  output logic                       pready,
  output logic                       pslverr,
  input  logic [NUM_STAT*DATA_W-1:0] status_value,
  output logic [NUM_CMD*DATA_W-1:0]  command_bus,
  output logic [NUM_CMD-1:0]         cmd_strobe
);

  localparam int NB = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              state;
  state_t              phase;
  logic [2:0]          wait_cnt;
  logic [ADDR_W-3:0]   addr_l;
  logic                write_l;
  logic [DATA_W-1:0]   wdata_l;
  logic [NB-1:0]       strb_l;
  logic [DATA_W-1:0]   cmd_q [NUM_CMD];
  logic [NUM_CMD-1:0]  strobe_q;
  logic [31:0]         word;
  logic [NUM_CMD-1:0]  cmd_sel;
  logic [NUM_STAT-1:0] stat_sel;
  logic                cmd_hit;
  logic                stat_hit;
  logic                done;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^paddr[1:0];

  // The SETUP phase is the master's setup cycle itself, so it is decoded from
  // the bus rather than held in the state register; this keeps WAIT_STATES=0
  // at the minimum two-cycle transfer.
  always_comb begin
    phase = IDLE;
    if (state == ACCESS)        phase = ACCESS;
    else if (psel && !penable)  phase = SETUP;
  end

  always_comb begin
    word = 32'(addr_l);
    for (int i = 0; i < NUM_CMD; i++)  cmd_sel[i]  = (word == 32'(i));
    for (int j = 0; j < NUM_STAT; j++) stat_sel[j] = (word == 32'(STAT_BASE / 4 + j));
    cmd_hit  = |cmd_sel;
    stat_hit = |stat_sel;
  end

  assign done    = (state == ACCESS) && psel && (wait_cnt == 3'd0);
  assign pready  = done;
  assign pslverr = done && !(cmd_hit || (stat_hit && !write_l));

  always_comb begin
    prdata = '0;
    if (done && !write_l) begin
      for (int i = 0; i < NUM_CMD; i++)
        if (cmd_sel[i]) prdata = cmd_q[i];
      if (!cmd_hit)
        for (int j = 0; j < NUM_STAT; j++)
          if (stat_sel[j]) prdata = status_value[j*DATA_W +: DATA_W];
    end
  end

  // Setup -> access boundary: capture the transfer attributes.
  always_ff @(posedge pclk) begin
    if (phase == SETUP) begin
      addr_l  <= paddr[ADDR_W-1:2];
      write_l <= pwrite;
      wdata_l <= pwdata;
      strb_l  <= pstrb;
    end
  end

  // Access -> completion boundary: register update and one-cycle strobe.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      strobe_q <= '0;
      for (int i = 0; i < NUM_CMD; i++) cmd_q[i] <= CMD_RESET;
    end else begin
      strobe_q <= '0;
      case (state)
        ACCESS: begin
          if (!psel) begin
            state <= IDLE;
          end else if (wait_cnt == 3'd0) begin
            state <= IDLE;
            if (write_l)
              for (int i = 0; i < NUM_CMD; i++)
                if (cmd_sel[i]) begin
                  strobe_q[i] <= 1'b1;
                  for (int b = 0; b < NB; b++)
                    if (strb_l[b]) cmd_q[i][8*b +: 8] <= wdata_l[8*b +: 8];
                end
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        default: begin
          if (phase == SETUP) begin
            state    <= ACCESS;
            wait_cnt <= 3'(WAIT_STATES);
          end
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CMD; i++) begin : g_cmd
    assign command_bus[i*DATA_W +: DATA_W] = cmd_q[i];
  end

  assign cmd_strobe = strobe_q;

endmodule

// File: tb/tb_apb_reg_bank.sv
// Directed bench for apb_reg_bank: three instances with WAIT_STATES 0, 3 and 2
// share the bus wires and differ only in psel.
module tb_apb_reg_bank;

  logic         pclk = 1'b0;
  logic         rst;
  logic [2:0]   psel;
  logic         penable;
  logic         pwrite;
  logic [7:0]   paddr;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [127:0] status_value;
  logic [31:0]  prdata [3];
  logic         pready [3];
  logic         pslverr [3];
  logic [127:0] command_bus [3];
  logic [3:0]   cmd_strobe [3];

  int pass_cnt = 0;
  int total = 0;

  localparam logic [127:0] ALL_A5 = {4{32'h0000_00A5}};

  always #5 pclk = ~pclk;

  apb_reg_bank #(.WAIT_STATES(0), .CMD_RESET(32'hA5)) u_ws0 (
    .pclk(pclk), .rst(rst), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata[0]),
    .pready(pready[0]), .pslverr(pslverr[0]), .status_value(status_value),
    .command_bus(command_bus[0]), .cmd_strobe(cmd_strobe[0]));

  apb_reg_bank #(.WAIT_STATES(3), .CMD_RESET(32'hA5)) u_ws3 (
    .pclk(pclk), .rst(rst), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata[1]),
    .pready(pready[1]), .pslverr(pslverr[1]), .status_value(status_value),
    .command_bus(command_bus[1]), .cmd_strobe(cmd_strobe[1]));

  apb_reg_bank #(.WAIT_STATES(2), .CMD_RESET(32'hA5)) u_ws2 (
    .pclk(pclk), .rst(rst), .psel(psel[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata[2]),
    .pready(pready[2]), .pslverr(pslverr[2]), .status_value(status_value),
    .command_bus(command_bus[2]), .cmd_strobe(cmd_strobe[2]));

  // One complete transfer on instance d; returns in the cycle after the completing edge.
  task automatic xfer(input int d, input logic wr, input logic [7:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      output logic [31:0] rdata, output logic err, output int nwait);
    logic fin;
    nwait = 0; rdata = '0; err = 1'b0; fin = 1'b0;
    @(posedge pclk); #1;
    psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(posedge pclk); #1;
    penable = 1'b1;
    while (!fin) begin
      @(negedge pclk);
      if (pready[d] === 1'b1) begin
        rdata = prdata[d]; err = pslverr[d]; fin = 1'b1;
      end else begin
        nwait++;
        if (nwait > 20) begin
          total++;
          $display("FAIL xfer_timeout dut=%0d addr=%h: pready never rose", d, addr);
          fin = 1'b1;
        end else begin
          @(posedge pclk); #1;
        end
      end
    end
    @(posedge pclk); #1;
    psel[d] = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge pclk);
    #1 rst = 1'b0;
    @(negedge pclk);
    for (int d = 0; d < 3; d++) begin
      total++; if (command_bus[d] !== ALL_A5) $display("FAIL reset_cmd dut=%0d got %h want %h", d, command_bus[d], ALL_A5); else pass_cnt++;
      total++; if ({pready[d], pslverr[d], cmd_strobe[d], prdata[d]} !== 38'd0)
        $display("FAIL reset_outs dut=%0d got rdy=%b err=%b stb=%b rd=%h want all 0", d, pready[d], pslverr[d], cmd_strobe[d], prdata[d]);
      else pass_cnt++;
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int nw;
    xfer(0, 1'b1, 8'h04, 32'h8000_0000, 4'hF, rd, er, nw);
    total++; if (nw !== 0) $display("FAIL wr_latency got %0d wait cycles want 0", nw); else pass_cnt++;
    total++; if (er !== 1'b0) $display("FAIL wr_err got %b want 0", er); else pass_cnt++;
    @(negedge pclk);
    total++; if (cmd_strobe[0] !== 4'b0010) $display("FAIL wr_strobe got %b want 0010", cmd_strobe[0]); else pass_cnt++;
    total++; if (command_bus[0][63:32] !== 32'h8000_0000) $display("FAIL wr_value got %h want 80000000", command_bus[0][63:32]); else pass_cnt++;
    @(negedge pclk);
    total++; if (cmd_strobe[0] !== 4'b0000) $display("FAIL wr_strobe_len got %b want 0000", cmd_strobe[0]); else pass_cnt++;
    xfer(0, 1'b0, 8'h04, 32'h0, 4'hF, rd, er, nw);
    total++; if (rd !== 32'h8000_0000) $display("FAIL rd_cmd1 got %h want 80000000", rd); else pass_cnt++;
    total++; if (er !== 1'b0) $display("FAIL rd_cmd1_err got %b want 0", er); else pass_cnt++;
    xfer(0, 1'b0, 8'h00, 32'h0, 4'hF, rd, er, nw);
    total++; if (rd !== 32'h0000_00A5) $display("FAIL rd_cmd0 got %h want 000000a5", rd); else pass_cnt++;
  endtask

  task automatic test_byte_strobe();
    logic [31:0] rd; logic er; int nw;
    xfer(0, 1'b1, 8'h00, 32'h1111_1111, 4'hF, rd, er, nw);
    xfer(0, 1'b1, 8'h00, 32'hAABB_CCDD, 4'b0101, rd, er, nw);
    xfer(0, 1'b0, 8'h00, 32'h0, 4'hF, rd, er, nw);
    total++; if (rd !== 32'h11BB_11DD) $display("FAIL strb_merge got %h want 11bb11dd", rd); else pass_cnt++;
    xfer(0, 1'b1, 8'h08, 32'hFFFF_FFFF, 4'b0000, rd, er, nw);
    @(negedge pclk);
    total++; if (cmd_strobe[0] !== 4'b0100) $display("FAIL strb_zero_pulse got %b want 0100", cmd_strobe[0]); else pass_cnt++;
    total++; if (command_bus[0][95:64] !== 32'h0000_00A5) $display("FAIL strb_zero_keep got %h want 000000a5", command_bus[0][95:64]); else pass_cnt++;
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int nw;
    logic [127:0] snap;
    snap = {32'h0000_00A5, 32'h0000_00A5, 32'h8000_0000, 32'h11BB_11DD};
    xfer(0, 1'b1, 8'h40, 32'hFFFF_FFFF, 4'hF, rd, er, nw);
    total++; if (er !== 1'b1) $display("FAIL err_wr_stat got %b want 1", er); else pass_cnt++;
    @(negedge pclk);
    total++; if (cmd_strobe[0] !== 4'b0000) $display("FAIL err_wr_stat_strobe got %b want 0000", cmd_strobe[0]); else pass_cnt++;
    total++; if (command_bus[0] !== snap) $display("FAIL err_wr_stat_keep got %h want %h", command_bus[0], snap); else pass_cnt++;
    xfer(0, 1'b1, 8'h10, 32'h1234_5678, 4'hF, rd, er, nw);
    total++; if (er !== 1'b1) $display("FAIL err_wr_unmapped got %b want 1", er); else pass_cnt++;
    @(negedge pclk);
    total++; if (command_bus[0] !== snap) $display("FAIL err_wr_unmapped_keep got %h want %h", command_bus[0], snap); else pass_cnt++;
    xfer(0, 1'b0, 8'hFC, 32'h0, 4'hF, rd, er, nw);
    total++; if ({rd, er} !== {32'h0, 1'b1}) $display("FAIL err_rd_unmapped got rd=%h err=%b want rd=0 err=1", rd, er); else pass_cnt++;
    status_value[31:0] = 32'h5555_0000;
    xfer(0, 1'b0, 8'h40, 32'h0, 4'hF, rd, er, nw);
    total++; if ({rd, er} !== {32'h5555_0000, 1'b0}) $display("FAIL rd_stat0 got rd=%h err=%b want rd=55550000 err=0", rd, er); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    @(posedge pclk); #1;
    psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h1; pstrb = 4'hF;
    @(posedge pclk); #1 penable = 1'b1;
    @(negedge pclk);
    total++; if (pready[0] !== 1'b1) $display("FAIL b2b_rdy1 got %b want 1", pready[0]); else pass_cnt++;
    @(posedge pclk); #1;
    penable = 1'b0; paddr = 8'h08; pwdata = 32'h2;
    @(negedge pclk);
    total++; if ({pready[0], cmd_strobe[0]} !== 5'b0_1000) $display("FAIL b2b_setup got rdy=%b stb=%b want rdy=0 stb=1000", pready[0], cmd_strobe[0]); else pass_cnt++;
    @(posedge pclk); #1 penable = 1'b1;
    @(negedge pclk);
    total++; if (pready[0] !== 1'b1) $display("FAIL b2b_rdy2 got %b want 1", pready[0]); else pass_cnt++;
    @(posedge pclk); #1;
    psel[0] = 1'b0; penable = 1'b0;
    @(negedge pclk);
    total++; if (cmd_strobe[0] !== 4'b0100) $display("FAIL b2b_strobe2 got %b want 0100", cmd_strobe[0]); else pass_cnt++;
    total++; if (command_bus[0][127:64] !== 64'h0000_0001_0000_0002) $display("FAIL b2b_values got %h want 0000000100000002", command_bus[0][127:64]); else pass_cnt++;
  endtask

  task automatic test_status();
    logic [31:0] rd; logic er; int nw;
    status_value[95:64] = 32'h7FFF_FFFF;
    xfer(1, 1'b0, 8'h48, 32'h0, 4'hF, rd, er, nw);
    total++; if (nw !== 3) $display("FAIL stat_wait got %0d wait cycles want 3", nw); else pass_cnt++;
    total++; if ({rd, er} !== {32'h7FFF_FFFF, 1'b0}) $display("FAIL stat_rd got rd=%h err=%b want rd=7fffffff err=0", rd, er); else pass_cnt++;
    status_value[95:64] = 32'h1234_5678;
    xfer(1, 1'b0, 8'h48, 32'h0, 4'hF, rd, er, nw);
    total++; if (rd !== 32'h1234_5678) $display("FAIL stat_rd_live got %h want 12345678", rd); else pass_cnt++;
    status_value[127:96] = 32'h0BAD_F00D;
    xfer(1, 1'b0, 8'h4C, 32'h0, 4'hF, rd, er, nw);
    total++; if (rd !== 32'h0BAD_F00D) $display("FAIL stat_rd_last got %h want 0badf00d", rd); else pass_cnt++;
    xfer(1, 1'b0, 8'h50, 32'h0, 4'hF, rd, er, nw);
    total++; if ({rd, er} !== {32'h0, 1'b1}) $display("FAIL stat_rd_past_end got rd=%h err=%b want rd=0 err=1", rd, er); else pass_cnt++;
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic er; int nw;
    @(posedge pclk); #1;
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'hDEAD_BEEF; pstrb = 4'hF;
    @(posedge pclk); #1 penable = 1'b1;
    @(negedge pclk);
    total++; if (pready[2] !== 1'b0) $display("FAIL abort_rdy_early got %b want 0", pready[2]); else pass_cnt++;
    @(posedge pclk); #1;
    psel[2] = 1'b0; penable = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge pclk);
      total++; if ({pready[2], cmd_strobe[2]} !== 5'b0) $display("FAIL abort_quiet cyc=%0d got rdy=%b stb=%b want 0", c, pready[2], cmd_strobe[2]); else pass_cnt++;
    end
    total++; if (command_bus[2] !== ALL_A5) $display("FAIL abort_keep got %h want %h", command_bus[2], ALL_A5); else pass_cnt++;
    xfer(2, 1'b0, 8'h00, 32'h0, 4'hF, rd, er, nw);
    total++; if (nw !== 2) $display("FAIL abort_next_wait got %0d want 2", nw); else pass_cnt++;
    total++; if (rd !== 32'h0000_00A5) $display("FAIL abort_next_rd got %h want 000000a5", rd); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int nw;
    xfer(2, 1'b1, 8'h0C, 32'h1234_5678, 4'hF, rd, er, nw);
    @(negedge pclk);
    total++; if (command_bus[2][127:96] !== 32'h1234_5678) $display("FAIL rstmid_pre got %h want 12345678", command_bus[2][127:96]); else pass_cnt++;
    @(posedge pclk); #1;
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 32'hCAFE_0000; pstrb = 4'hF;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1 rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge pclk);
      total++; if (pready[2] !== 1'b0) $display("FAIL rstmid_rdy cyc=%0d got %b want 0", c, pready[2]); else pass_cnt++;
    end
    @(posedge pclk); #1 rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge pclk);
      total++; if ({pready[2], cmd_strobe[2]} !== 5'b0) $display("FAIL rstmid_after cyc=%0d got rdy=%b stb=%b want 0", c, pready[2], cmd_strobe[2]); else pass_cnt++;
    end
    total++; if (command_bus[2] !== ALL_A5) $display("FAIL rstmid_regs got %h want %h", command_bus[2], ALL_A5); else pass_cnt++;
    @(posedge pclk); #1;
    psel[2] = 1'b0; penable = 1'b0;
  endtask

  initial begin
    rst = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
    pwdata = '0; pstrb = '0; status_value = '0;
    test_reset();
    test_write_read();
    test_byte_strobe();
    test_errors();
    test_back_to_back();
    test_status();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
